// File: rtl/load_buffer.sv
// load_buffer: in-order load queue sitting between the address unit and the
// memory controller. Loads are issued one at a time, their returned data is
// sign- or zero-extended, and the result is broadcast on the load lane of the
// common data bus for the reservation stations and the ROB to snoop.
// Optional feature: define LBUFFER_IO_ORDER_EN to hold loads that target the
// memory-mapped I/O region (address >= 0x30000) until they reach the ROB head.
// Opcode encodings match the shared constant table used by the rest of the core.

module load_buffer #(
    parameter int DEPTH      = 4,
    parameter int ID_WIDTH   = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int OP_WIDTH   = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,

    input  logic                  addrunit_lbuffer_en_in,
    input  logic [ADDR_WIDTH-1:0] addrunit_lbuffer_addr_in,
    input  logic [ROB_WIDTH-1:0]  addrunit_lbuffer_dest_in,
    input  logic [OP_WIDTH-1:0]   addrunit_lbuffer_opcode_in,

    output logic                  lbuffer_rs_rdy_out,

    output logic                  lbuffer_memctrl_en_out,
    output logic [ADDR_WIDTH-1:0] lbuffer_memctrl_addr_out,
    output logic [2:0]            lbuffer_memctrl_len_out,
    input  logic                  memctrl_lbuffer_rdy_in,
    input  logic [ID_WIDTH-1:0]   memctrl_lbuffer_data_in,

    input  logic                  rob_lbuffer_rst_in,
    input  logic [ROB_WIDTH-1:0]  rob_lbuffer_head_in,

    output logic [ROB_WIDTH-1:0]  cdb_lbuffer_b_out,
    output logic [ID_WIDTH-1:0]   cdb_lbuffer_result_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [OP_WIDTH-1:0] LB  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] LH  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] LW  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] LBU = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] LHU = OP_WIDTH'(5);

    // Two free slots are needed because a load leaving RS lands here one cycle later.
    localparam logic [CW-1:0] RS_RDY_LIMIT = CW'(DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BCAST,
        S_DISCARD
    } state_t;

    state_t state;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [ROB_WIDTH-1:0]  dest_mem [DEPTH];
    logic [OP_WIDTH-1:0]   op_mem   [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [ADDR_WIDTH-1:0] head_addr;
    logic [ROB_WIDTH-1:0]  head_dest;
    logic [OP_WIDTH-1:0]   head_op;
    logic                  issue_gate;
    logic                  enq;
    logic                  pop;

    // Byte count requested from the memory controller for a given load type.
    function automatic logic [2:0] len_of(input logic [OP_WIDTH-1:0] op);
        case (op)
            LB, LBU: len_of = 3'd1;
            LH, LHU: len_of = 3'd2;
            default: len_of = 3'd4;
        endcase
    endfunction

    // Widen the little-endian, zero-filled memory data to a register value.
    function automatic logic [ID_WIDTH-1:0] extend(input logic [OP_WIDTH-1:0] op,
                                                   input logic [ID_WIDTH-1:0] data);
        case (op)
            LB:      extend = {{(ID_WIDTH-8){data[7]}}, data[7:0]};
            LH:      extend = {{(ID_WIDTH-16){data[15]}}, data[15:0]};
            LBU:     extend = {{(ID_WIDTH-8){1'b0}}, data[7:0]};
            LHU:     extend = {{(ID_WIDTH-16){1'b0}}, data[15:0]};
            LW:      extend = data;
            default: extend = data;
        endcase
    endfunction

    assign head_addr = addr_mem[head];
    assign head_dest = dest_mem[head];
    assign head_op   = op_mem[head];

    // A flush wins over a same-cycle enqueue: the new load belongs to the squashed path.
    assign enq = addrunit_lbuffer_en_in && !rob_lbuffer_rst_in;
    assign pop = (state == S_BCAST) && !rob_lbuffer_rst_in;

    assign lbuffer_rs_rdy_out = (count <= RS_RDY_LIMIT);

`ifdef LBUFFER_IO_ORDER_EN
    localparam logic [ADDR_WIDTH-1:0] IO_BASE = ADDR_WIDTH'(32'h30000);

    // I/O loads have side effects, so they wait until they are the oldest instruction.
    assign issue_gate = (head_addr < IO_BASE) || (rob_lbuffer_head_in == head_dest);
`else
    logic unused_rob_head;

    assign unused_rob_head = ^rob_lbuffer_head_in;
    assign issue_gate      = 1'b1;
`endif

    // Entry storage: written at the tail on every accepted enqueue, never reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && enq) begin
            addr_mem[tail] <= addrunit_lbuffer_addr_in;
            dest_mem[tail] <= addrunit_lbuffer_dest_in;
            op_mem[tail]   <= addrunit_lbuffer_opcode_in;
        end
    end

    // Queue pointers, occupancy and the issue/wait/broadcast sequencer with registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                    <= S_IDLE;
            head                     <= '0;
            tail                     <= '0;
            count                    <= '0;
            lbuffer_memctrl_en_out   <= 1'b0;
            lbuffer_memctrl_addr_out <= '0;
            lbuffer_memctrl_len_out  <= 3'd0;
            cdb_lbuffer_b_out        <= '0;
            cdb_lbuffer_result_out   <= '0;
        end else if (rdy_in) begin
            lbuffer_memctrl_en_out <= 1'b0;
            cdb_lbuffer_b_out      <= '0;

            if (rob_lbuffer_rst_in) begin
                head                   <= '0;
                tail                   <= '0;
                count                  <= '0;
                cdb_lbuffer_result_out <= '0;
                case (state)
                    S_WAIT:    state <= memctrl_lbuffer_rdy_in ? S_IDLE : S_DISCARD;
                    S_DISCARD: state <= memctrl_lbuffer_rdy_in ? S_IDLE : S_DISCARD;
                    default:   state <= S_IDLE;
                endcase
            end else begin
                if (enq) begin
                    tail <= tail + PW'(1);
                end

                case ({enq, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase

                case (state)
                    S_IDLE: begin
                        if (count != '0 && issue_gate) begin
                            lbuffer_memctrl_en_out   <= 1'b1;
                            lbuffer_memctrl_addr_out <= head_addr;
                            lbuffer_memctrl_len_out  <= len_of(head_op);
                            state                    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (memctrl_lbuffer_rdy_in) begin
                            cdb_lbuffer_b_out      <= head_dest;
                            cdb_lbuffer_result_out <= extend(head_op, memctrl_lbuffer_data_in);
                            state                  <= S_BCAST;
                        end
                    end
                    S_BCAST: begin
                        head  <= head + PW'(1);
                        state <= S_IDLE;
                    end
                    S_DISCARD: begin
                        if (memctrl_lbuffer_rdy_in) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_load_buffer.sv
// tb_load_buffer: directed and randomized bench for load_buffer. The bench acts
// as address unit, memory controller and ROB, keeps its own queue of pending
// loads, and predicts request length and broadcast values from the load type.
// Builds with or without LBUFFER_IO_ORDER_EN; the I/O ordering step follows it.

module tb_load_buffer;

    localparam int DEPTH      = 4;
    localparam int ID_WIDTH   = 32;
    localparam int ROB_WIDTH  = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int OP_WIDTH   = 6;

    localparam logic [5:0] LB  = 6'd1;
    localparam logic [5:0] LH  = 6'd2;
    localparam logic [5:0] LW  = 6'd3;
    localparam logic [5:0] LBU = 6'd4;
    localparam logic [5:0] LHU = 6'd5;
    localparam logic [5:0] OP_TABLE [5] = '{LB, LH, LW, LBU, LHU};

    logic                  clk_in = 1'b0;
    logic                  rst_in = 1'b1;
    logic                  rdy_in = 1'b1;
    logic                  addrunit_lbuffer_en_in = 1'b0;
    logic [ADDR_WIDTH-1:0] addrunit_lbuffer_addr_in = '0;
    logic [ROB_WIDTH-1:0]  addrunit_lbuffer_dest_in = '0;
    logic [OP_WIDTH-1:0]   addrunit_lbuffer_opcode_in = '0;
    logic                  lbuffer_rs_rdy_out;
    logic                  lbuffer_memctrl_en_out;
    logic [ADDR_WIDTH-1:0] lbuffer_memctrl_addr_out;
    logic [2:0]            lbuffer_memctrl_len_out;
    logic                  memctrl_lbuffer_rdy_in = 1'b0;
    logic [ID_WIDTH-1:0]   memctrl_lbuffer_data_in = '0;
    logic                  rob_lbuffer_rst_in = 1'b0;
    logic [ROB_WIDTH-1:0]  rob_lbuffer_head_in = '0;
    logic [ROB_WIDTH-1:0]  cdb_lbuffer_b_out;
    logic [ID_WIDTH-1:0]   cdb_lbuffer_result_out;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  dest;
        logic [5:0]  op;
    } load_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  len;
        int          cyc;
    } issue_t;

    typedef struct {
        logic [3:0]  b;
        logic [31:0] result;
        int          cyc;
    } bcast_t;

    load_t       pend[$];
    issue_t      issuedQ[$];
    bcast_t      cdbQ[$];
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    logic        outstanding = 1'b0;
    logic        prevEn = 1'b0;
    logic [3:0]  prevB = '0;
    logic [31:0] lastResult = '0;

    load_buffer #(
        .DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH), .ROB_WIDTH(ROB_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .OP_WIDTH(OP_WIDTH)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .addrunit_lbuffer_en_in(addrunit_lbuffer_en_in),
        .addrunit_lbuffer_addr_in(addrunit_lbuffer_addr_in),
        .addrunit_lbuffer_dest_in(addrunit_lbuffer_dest_in),
        .addrunit_lbuffer_opcode_in(addrunit_lbuffer_opcode_in),
        .lbuffer_rs_rdy_out(lbuffer_rs_rdy_out),
        .lbuffer_memctrl_en_out(lbuffer_memctrl_en_out),
        .lbuffer_memctrl_addr_out(lbuffer_memctrl_addr_out),
        .lbuffer_memctrl_len_out(lbuffer_memctrl_len_out),
        .memctrl_lbuffer_rdy_in(memctrl_lbuffer_rdy_in),
        .memctrl_lbuffer_data_in(memctrl_lbuffer_data_in),
        .rob_lbuffer_rst_in(rob_lbuffer_rst_in),
        .rob_lbuffer_head_in(rob_lbuffer_head_in),
        .cdb_lbuffer_b_out(cdb_lbuffer_b_out),
        .cdb_lbuffer_result_out(cdb_lbuffer_result_out)
    );

    // Free-running 10-unit clock.
    initial begin
        forever #5 clk_in = ~clk_in;
    end

    // Hard stop in case anything unforeseen stalls the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Request length the memory controller should be asked for.
    function automatic logic [2:0] expLen(input logic [5:0] op);
        if (op == LB || op == LBU) return 3'd1;
        if (op == LH || op == LHU) return 3'd2;
        return 3'd4;
    endfunction

    // The memory controller returns zeros above the requested length.
    function automatic logic [31:0] lenMask(input logic [5:0] op);
        case (expLen(op))
            3'd1:    return 32'h0000_00FF;
            3'd2:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Architectural value of a load, computed as a signed/unsigned integer.
    function automatic logic [31:0] expValue(input logic [5:0] op, input logic [31:0] data);
        longint v;
        case (op)
            LB: begin
                v = longint'(data % 256);
                if (v >= 128) v = v - 256;
            end
            LH: begin
                v = longint'(data % 65536);
                if (v >= 32768) v = v - 65536;
            end
            LBU:     v = longint'(data % 256);
            LHU:     v = longint'(data % 65536);
            default: v = longint'(data);
        endcase
        return v[31:0];
    endfunction

    // One comparison: counts it, and reports tag/observed/expected on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    // Monitor: records every memory request and every CDB broadcast with its edge index.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            cycle++;
            if (!rst_in && rdy_in) begin
                if (lbuffer_memctrl_en_out) begin
                    checkOutput("en_single_pulse", prevEn, 0);
                    checkOutput("one_outstanding", outstanding, 0);
                    outstanding = 1'b1;
                    issuedQ.push_back('{lbuffer_memctrl_addr_out, lbuffer_memctrl_len_out, cycle});
                end
                if (cdb_lbuffer_b_out != '0) begin
                    checkOutput("cdb_single_cycle", prevB, 0);
                    cdbQ.push_back('{cdb_lbuffer_b_out, cdb_lbuffer_result_out, cycle});
                end
            end
            prevEn = lbuffer_memctrl_en_out;
            prevB  = cdb_lbuffer_b_out;
        end
    end

    // Address unit: present one load for one edge and add it to the pending model.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] dest,
                                 input logic [5:0] op, output int enqEdge);
        if (pend.size() >= DEPTH) begin
            $display("[TB] FAIL overflow_guard observed=%0d expected<%0d", pend.size(), DEPTH);
            $fatal(1, "[TB] bench would write a full buffer");
        end
        addrunit_lbuffer_en_in     = 1'b1;
        addrunit_lbuffer_addr_in   = addr;
        addrunit_lbuffer_dest_in   = dest;
        addrunit_lbuffer_opcode_in = op;
        tick();
        enqEdge = cycle;
        addrunit_lbuffer_en_in = 1'b0;
        pend.push_back('{addr, dest, op});
        checkOutput("rs_rdy_after_enq", lbuffer_rs_rdy_out, (DEPTH - pend.size()) >= 2);
    endtask

    // Wait (bounded) for the next memory request seen by the monitor.
    task automatic waitIssue(output issue_t it, output bit ok);
        for (int i = 0; i < 40; i++) begin
            if (issuedQ.size() > 0) break;
            tick();
        end
        ok = (issuedQ.size() > 0);
        checkOutput("issue_seen", ok, 1);
        it = '{32'h0, 3'd0, -1};
        if (ok) it = issuedQ.pop_front();
    endtask

    // Memory controller: serve the oldest pending load and check its broadcast.
    task automatic serviceOne(input int delay, input logic [31:0] raw,
                              output int issueEdge, output int respEdge);
        issue_t      it;
        bcast_t      bc;
        load_t       ld;
        bit          ok;
        logic [31:0] data;
        issueEdge = -1;
        respEdge  = -1;
        waitIssue(it, ok);
        if (!ok || pend.size() == 0) return;
        ld = pend[0];
        checkOutput("issue_addr", it.addr, ld.addr);
        checkOutput("issue_len", it.len, expLen(ld.op));
        issueEdge = it.cyc;
        repeat (delay) tick();
        data = raw & lenMask(ld.op);
        memctrl_lbuffer_rdy_in  = 1'b1;
        memctrl_lbuffer_data_in = data;
        tick();
        respEdge = cycle;
        memctrl_lbuffer_rdy_in  = 1'b0;
        memctrl_lbuffer_data_in = '0;
        outstanding = 1'b0;
        tick();
        ok = (cdbQ.size() > 0);
        checkOutput("bcast_seen", ok, 1);
        if (ok) begin
            bc = cdbQ.pop_front();
            lastResult = bc.result;
            checkOutput("bcast_tag", bc.b, ld.dest);
            checkOutput("bcast_value", bc.result, expValue(ld.op, data));
            checkOutput("bcast_latency", bc.cyc, respEdge);
        end
        void'(pend.pop_front());
        checkOutput("rs_rdy_after_pop", lbuffer_rs_rdy_out, (DEPTH - pend.size()) >= 2);
    endtask

    // Directed sequence followed by randomized batches.
    initial begin
        int     e, e2, ie, re, re1, staleEdge, flushEdge, headEdge, k;
        issue_t it;
        bit     ok;

        // Reset: everything idle, buffer reports room.
        repeat (3) tick();
        rst_in = 1'b0;
        tick();
        checkOutput("reset_en", lbuffer_memctrl_en_out, 0);
        checkOutput("reset_addr", lbuffer_memctrl_addr_out, 0);
        checkOutput("reset_len", lbuffer_memctrl_len_out, 0);
        checkOutput("reset_cdb_b", cdb_lbuffer_b_out, 0);
        checkOutput("reset_cdb_result", cdb_lbuffer_result_out, 0);
        checkOutput("reset_rs_rdy", lbuffer_rs_rdy_out, 1);

        // Signed and unsigned byte loads, with minimum issue latency.
        applyStimulus(32'h100, 4'd3, LB, e);
        serviceOne(0, 32'h80, ie, re);
        checkOutput("lb_issue_latency", ie, e + 1);
        checkOutput("lb_result", lastResult, 32'hFFFF_FF80);
        applyStimulus(32'h100, 4'd3, LBU, e);
        serviceOne(0, 32'h80, ie, re);
        checkOutput("lbu_issue_latency", ie, e + 1);
        checkOutput("lbu_result", lastResult, 32'h0000_0080);

        // Halfword then word back-to-back: second request follows the first broadcast.
        applyStimulus(32'h200, 4'd1, LH, e);
        applyStimulus(32'h204, 4'd2, LW, e2);
        serviceOne(1, 32'h8001, ie, re1);
        checkOutput("lh_result", lastResult, 32'hFFFF_8001);
        serviceOne(2, 32'h1234_5678, ie, re);
        checkOutput("lw_issue_after_bcast", ie, re1 + 2);
        checkOutput("lw_result", lastResult, 32'h1234_5678);

        // Fill with memory stalled, then drain through the pointer wrap.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(32'($urandom_range(0, 32'h2FFFF)), 4'($urandom_range(1, 15)),
                          OP_TABLE[$urandom_range(0, 4)], e);
        end
        checkOutput("full_rs_rdy_low", lbuffer_rs_rdy_out, 0);
        for (int i = 0; i < DEPTH; i++) begin
            serviceOne($urandom_range(0, 3), $urandom, ie, re);
        end

        // Flush while waiting: stale response is swallowed before the next load issues.
        applyStimulus(32'h300, 4'd6, LW, e);
        waitIssue(it, ok);
        checkOutput("flush_wait_issue_addr", it.addr, 32'h300);
        rob_lbuffer_rst_in = 1'b1;
        tick();
        rob_lbuffer_rst_in = 1'b0;
        pend.delete();
        checkOutput("flush_rs_rdy", lbuffer_rs_rdy_out, 1);
        applyStimulus(32'h304, 4'd7, LH, e);
        tick();
        checkOutput("discard_no_issue", issuedQ.size(), 0);
        memctrl_lbuffer_rdy_in  = 1'b1;
        memctrl_lbuffer_data_in = 32'hDEAD_BEEF;
        tick();
        staleEdge = cycle;
        memctrl_lbuffer_rdy_in  = 1'b0;
        memctrl_lbuffer_data_in = '0;
        outstanding = 1'b0;
        checkOutput("discard_no_bcast", cdbQ.size(), 0);
        checkOutput("discard_no_issue_yet", issuedQ.size(), 0);
        serviceOne(0, $urandom, ie, re);
        checkOutput("post_discard_issue", ie, staleEdge + 1);

        // Flush with the response and an enqueue in the same cycle: both are dropped.
        applyStimulus(32'h400, 4'd8, LBU, e);
        waitIssue(it, ok);
        rob_lbuffer_rst_in         = 1'b1;
        memctrl_lbuffer_rdy_in     = 1'b1;
        memctrl_lbuffer_data_in    = 32'h55;
        addrunit_lbuffer_en_in     = 1'b1;
        addrunit_lbuffer_addr_in   = 32'h999;
        addrunit_lbuffer_dest_in   = 4'd9;
        addrunit_lbuffer_opcode_in = LB;
        tick();
        flushEdge = cycle;
        rob_lbuffer_rst_in      = 1'b0;
        memctrl_lbuffer_rdy_in  = 1'b0;
        memctrl_lbuffer_data_in = '0;
        addrunit_lbuffer_en_in  = 1'b0;
        outstanding = 1'b0;
        pend.delete();
        checkOutput("flush_resp_no_bcast", cdbQ.size(), 0);
        applyStimulus(32'h408, 4'd10, LHU, e);
        checkOutput("flush_resp_enq_edge", e, flushEdge + 1);
        serviceOne(0, $urandom, ie, re);
        checkOutput("flush_resp_to_idle", ie, e + 1);

        // Global stall mid-wait with the response held until the stall ends.
        applyStimulus(32'h500, 4'd11, LH, e);
        waitIssue(it, ok);
        tick();
        rdy_in                  = 1'b0;
        memctrl_lbuffer_rdy_in  = 1'b1;
        memctrl_lbuffer_data_in = 32'h8123;
        repeat (5) tick();
        checkOutput("freeze_no_bcast", cdbQ.size(), 0);
        checkOutput("freeze_no_issue", issuedQ.size(), 0);
        rdy_in = 1'b1;
        tick();
        re = cycle;
        memctrl_lbuffer_rdy_in  = 1'b0;
        memctrl_lbuffer_data_in = '0;
        outstanding = 1'b0;
        tick();
        checkOutput("freeze_bcast_count", cdbQ.size(), 1);
        if (cdbQ.size() > 0) begin
            bcast_t bc;
            bc = cdbQ.pop_front();
            checkOutput("freeze_bcast_tag", bc.b, 11);
            checkOutput("freeze_bcast_value", bc.result, expValue(LH, 32'h8123));
            checkOutput("freeze_bcast_latency", bc.cyc, re);
        end
        void'(pend.pop_front());

        // Memory-mapped I/O load with the ROB head elsewhere.
        rob_lbuffer_head_in = 4'd4;
        applyStimulus(32'h30000, 4'd5, LW, e);
`ifdef LBUFFER_IO_ORDER_EN
        repeat (4) tick();
        checkOutput("io_held", issuedQ.size(), 0);
        rob_lbuffer_head_in = 4'd5;
        tick();
        headEdge = cycle;
        serviceOne(0, $urandom, ie, re);
        checkOutput("io_issue_at_head", ie, headEdge);
`else
        headEdge = e + 1;
        serviceOne(0, $urandom, ie, re);
        checkOutput("io_issue_ungated", ie, headEdge);
`endif
        rob_lbuffer_head_in = '0;

        // Randomized batches: enqueue a burst, then serve it with random memory delays.
        for (int b = 0; b < 10; b++) begin
            k = $urandom_range(1, DEPTH);
            for (int j = 0; j < k; j++) begin
                applyStimulus(32'($urandom_range(0, 32'h2FFFF)), 4'($urandom_range(1, 15)),
                              OP_TABLE[$urandom_range(0, 4)], e);
            end
            for (int j = 0; j < k; j++) begin
                serviceOne($urandom_range(0, 3), $urandom, ie, re);
            end
        end

        repeat (2) tick();
        checkOutput("final_no_stray_issue", issuedQ.size(), 0);
        checkOutput("final_no_stray_bcast", cdbQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
